grid_cursor_ctrl: RTL and testbench
===================================

# grid_cursor_ctrl

Initiator side of the grid draw interface. It owns the 12x12 step grid state and the cursor position, turns debounced button pulses into cursor moves and step toggles, and issues draw requests to `vga_display`. Each request makes the display paint the new cursor cell red and repaint the previous cell in its step colour. It sits between the button debouncers and `vga_display`, and exposes a column read port to the playback sequencer.

## Interface
- `GRID_N`, 12: cells per row and per column.
- `X0`, 214: pixel x of cell column 0.
- `Y0`, 32: pixel y of cell row 0.
- `PITCH`, 33: cell-to-cell pixel pitch.
- `CLOCK_50  in  1`: clock, all logic on the rising edge.
- `nReset  in  1`: reset, asynchronous, active-low.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  `in  1` each: one-cycle move pulses.
- `btn_toggle  in  1`: one-cycle pulse that toggles the step at the cursor.
- `drawing  in  1`: busy flag from the display.
- `draw_enable  out  1`: one-cycle draw start pulse.
- `X  out  10`, `Y  out  9`: pixel origin of the new cursor cell.
- `OLD_X  out  10`, `OLD_Y  out  9`: pixel origin of the previous cursor cell.
- `state  out  1`: step bit of the previous cell (1 = blue).
- `cursor_col  out  4`, `cursor_row  out  4`: current cursor cell.
- `busy  out  1`: high from reset until the current request completes.
- `play_col  in  4`, `play_bits  out  12`: column read port; bit r of `play_bits` is row r.

## Operation
- **FSM states**
  - `INIT_HI`: wait for `drawing`=1, the display's initial grid paint.
  - `INIT_LO`: wait for `drawing`=0.
  - `IDLE`.
  - `LAUNCH`: assert `draw_enable`.
  - `WAIT_CUR_HI`, `WAIT_CUR_LO`: cursor paint.
  - `WAIT_BOX_HI`, `WAIT_BOX_LO`: box paint.
  - Completion of `WAIT_BOX_LO` returns to `IDLE`.
- **Transitions**
  - `INIT_HI` → `INIT_LO` on `drawing`=1.
  - `INIT_LO` → `IDLE` on `drawing`=0.
  - `IDLE` → `LAUNCH` when a move is pending.
  - `LAUNCH` → `WAIT_CUR_HI` unconditionally.
  - Each `*_HI` → `*_LO` on `drawing`=1.
  - `WAIT_CUR_LO` → `WAIT_BOX_HI` on `drawing`=0.
  - `WAIT_BOX_LO` → `IDLE` on `drawing`=0.
- **Moves**
  - Priority when pulses coincide: up > down > left > right.
  - Up means row−1, down row+1, left col−1, right col+1.
  - Cursor wraps around: 0−1 → 11, 11+1 → 0.
- **Pending buffer**
  - One-entry move buffer.
  - A move pulse in any state sets the buffer, overwriting an older entry.
  - The buffer is consumed on entry to `LAUNCH`.
- **Launch**, in the cycle entering `LAUNCH`:
  - Latch `OLD_X`/`OLD_Y` and `state` from the current cell, using the grid bit before any same-cycle toggle.
  - Update the cursor.
  - Latch `X`/`Y` from the new cell.
- **Output stability**: all of `X`, `Y`, `OLD_X`, `OLD_Y` and `state` hold constant from `LAUNCH` until return to `IDLE`.
- **Toggle**
  - Accepted in every state.
  - Flips `grid[cursor_row][cursor_col]` at the edge.
  - Never triggers a draw; the cursor cell is already red.
  - If a toggle and a launch happen in the same cycle, the toggle applies to the pre-move cell.
- **Arithmetic**
  - X = X0 + col·PITCH, max 577.
  - Y = Y0 + row·PITCH, max 395.
  - Computed at 10/9-bit width with no truncation.
- **Reset values**
  - FSM in `INIT_HI`, `busy`=1, `draw_enable`=0.
  - Cursor (0,0); `X`=`OLD_X`=214, `Y`=`OLD_Y`=32.
  - `state`=0, whole grid 0, `play_bits`=0, pending buffer empty.
- **Reset mid-operation** returns to `INIT_HI` and discards the pending move. The display shares `nReset`, so both restart together.

## Timing
- `draw_enable` is high for exactly one cycle, the `LAUNCH` cycle. It never re-asserts before return to `IDLE`.
- A move pulse in `IDLE` at cycle t gives `LAUNCH` at t+1.
- The display raises `drawing` at t+2.
- The one-cycle `drawing` dip between cursor and box paint is consumed by `WAIT_CUR_LO` → `WAIT_BOX_HI`. It must never be treated as completion.
- `busy` = (state ≠ `IDLE`) or pending move.
- `play_bits` is registered: `play_col` at cycle t is reflected at t+1 and includes toggles committed at edge t.
- A `play_col` value ≥ 12 returns 0.

## Structure
- **Package `grid_pkg`**: `GRID_N`, `X0`, `Y0`, `PITCH`, `CELL`=31, and the FSM state enum.
- **Sub-module `step_grid_store`**:
  - Holds the 144-bit grid.
  - Toggle write port (row, col, `en`).
  - Single-cell combinational read for `state`.
  - Registered column read for `play_bits`.
- The controller FSM, move buffer and pixel arithmetic live in `grid_cursor_ctrl`.

## Test plan
- **Reset and init**: reset, then a `drawing` model high for 10 cycles then low → `busy` falls. Outputs read `X`=214, `Y`=32, `OLD_X`=214, `OLD_Y`=32, `state`=0.
- **Right move**: `btn_right` in `IDLE` → `draw_enable` one cycle later, `X`=247, `OLD_X`=214, `state`=0. `busy` holds through both `drawing` pulses, including the one-cycle dip.
- **Wrap-around**: `btn_left` at col 0 → col 11, `X`=577. `btn_up` at row 0 → row 11, `Y`=395.
- **Toggle then move**: `btn_toggle` at (0,0), then `btn_right` → `state`=1, `OLD_X`=214. Read `play_col`=0 → `play_bits`=12'h001.
- **Buffering and priority**:
  - `btn_down` + `btn_left` in the same cycle → only the down move.
  - Two moves during busy → only the last executes after completion.
  - Exactly 2 `draw_enable` pulses in total.
- **Async reset mid-request**: assert `nReset` low during `WAIT_BOX_HI` → all outputs at reset values immediately. The grid is cleared and the pending move is dropped.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared constants, FSM state encoding and pixel/cursor helpers for the step-grid cursor controller.
package grid_pkg;

    localparam int GRID_N = 12;
    localparam int X0     = 214;
    localparam int Y0     = 32;
    localparam int PITCH  = 33;
    localparam int CELL   = 31;

    localparam logic [3:0] LAST_IDX = 4'(GRID_N - 1);
    localparam logic [3:0] GRID_N4  = 4'(GRID_N);

    typedef enum logic [2:0] {
        INIT_HI,
        INIT_LO,
        IDLE,
        LAUNCH,
        WAIT_CUR_HI,
        WAIT_CUR_LO,
        WAIT_BOX_HI,
        WAIT_BOX_LO
    } ctrl_state_t;

    typedef enum logic [1:0] {
        MV_UP,
        MV_DOWN,
        MV_LEFT,
        MV_RIGHT
    } move_dir_t;

    typedef struct packed {
        logic      vld;
        move_dir_t dir;
    } move_req_t;

    // Worst case 214 + 11*33 = 577 fits in 10 bits, 32 + 363 = 395 fits in 9.
    function automatic logic [9:0] cell_x(input logic [3:0] col);
        return 10'(X0) + 10'(col) * 10'(PITCH);
    endfunction

    function automatic logic [8:0] cell_y(input logic [3:0] row);
        return 9'(Y0) + 9'(row) * 9'(PITCH);
    endfunction

    function automatic logic [3:0] wrap_inc(input logic [3:0] v);
        return (v == LAST_IDX) ? 4'd0 : v + 4'd1;
    endfunction

    function automatic logic [3:0] wrap_dec(input logic [3:0] v);
        return (v == 4'd0) ? LAST_IDX : v - 4'd1;
    endfunction

endpackage

// File: rtl/step_grid_store.sv
// 12x12 step bit storage: toggle write port, combinational cell read, registered column read.
module step_grid_store
    import grid_pkg::*;
(
    input  logic               CLOCK_50,
    input  logic               nReset,
    input  logic               tgl_en,
    input  logic [3:0]         tgl_row,
    input  logic [3:0]         tgl_col,
    input  logic [3:0]         rd_row,
    input  logic [3:0]         rd_col,
    output logic               rd_bit,
    input  logic [3:0]         play_col,
    output logic [GRID_N-1:0]  play_bits
);

    logic [GRID_N-1:0][GRID_N-1:0] grid_q;
    logic [GRID_N-1:0][GRID_N-1:0] grid_d;
    logic [GRID_N-1:0]             play_d;

    // The column read looks at grid_d so a toggle on the same edge is already visible.
    for (genvar r = 0; r < GRID_N; r++) begin : g_row
        for (genvar c = 0; c < GRID_N; c++) begin : g_col
            assign grid_d[r][c] = grid_q[r][c] ^
                (tgl_en && (tgl_row == 4'(r)) && (tgl_col == 4'(c)));
        end
        assign play_d[r] = (play_col < GRID_N4) ? grid_d[r][play_col] : 1'b0;
    end

    assign rd_bit = grid_q[rd_row][rd_col];

    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            grid_q    <= '0;
            play_bits <= '0;
        end else begin
            grid_q    <= grid_d;
            play_bits <= play_d;
        end
    end

endmodule

// File: rtl/grid_cursor_ctrl.sv
// Cursor/step-grid controller: buffers button moves and sequences draw requests to the display.
module grid_cursor_ctrl
    import grid_pkg::*;
(
    input  logic               CLOCK_50,
    input  logic               nReset,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_toggle,
    input  logic               drawing,
    output logic               draw_enable,
    output logic [9:0]         X,
    output logic [8:0]         Y,
    output logic [9:0]         OLD_X,
    output logic [8:0]         OLD_Y,
    output logic               state,
    output logic [3:0]         cursor_col,
    output logic [3:0]         cursor_row,
    output logic               busy,
    input  logic [3:0]         play_col,
    output logic [GRID_N-1:0]  play_bits
);

    ctrl_state_t fsm_q, fsm_d;
    move_req_t   pend_q;
    move_dir_t   in_dir, launch_dir;
    logic        move_any, move_req, launch, cur_bit;
    logic [3:0]  nxt_col, nxt_row;

    assign move_any = btn_up | btn_down | btn_left | btn_right;

    always_comb begin
        in_dir = MV_RIGHT;
        if (btn_up)        in_dir = MV_UP;
        else if (btn_down) in_dir = MV_DOWN;
        else if (btn_left) in_dir = MV_LEFT;
    end

    // A pulse arriving in IDLE launches at once rather than waiting a cycle in the buffer.
    assign launch_dir = move_any ? in_dir : pend_q.dir;
    assign move_req   = move_any | pend_q.vld;

    always_comb begin
        nxt_col = cursor_col;
        nxt_row = cursor_row;
        case (launch_dir)
            MV_UP:    nxt_row = wrap_dec(cursor_row);
            MV_DOWN:  nxt_row = wrap_inc(cursor_row);
            MV_LEFT:  nxt_col = wrap_dec(cursor_col);
            MV_RIGHT: nxt_col = wrap_inc(cursor_col);
            default:  ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) fsm_q <= INIT_HI;
        else         fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d       = fsm_q;
        draw_enable = 1'b0;
        launch      = 1'b0;
        case (fsm_q)
            INIT_HI:     if (drawing)  fsm_d = INIT_LO;
            INIT_LO:     if (!drawing) fsm_d = IDLE;
            IDLE: begin
                if (move_req) begin
                    fsm_d  = LAUNCH;
                    launch = 1'b1;
                end
            end
            LAUNCH: begin
                draw_enable = 1'b1;
                fsm_d       = WAIT_CUR_HI;
            end
            WAIT_CUR_HI: if (drawing)  fsm_d = WAIT_CUR_LO;
            // The low cycle between cursor and box paint only advances to the box wait.
            WAIT_CUR_LO: if (!drawing) fsm_d = WAIT_BOX_HI;
            WAIT_BOX_HI: if (drawing)  fsm_d = WAIT_BOX_LO;
            WAIT_BOX_LO: if (!drawing) fsm_d = IDLE;
            default:     fsm_d = INIT_HI;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset)       pend_q <= '0;
        else if (launch)   pend_q <= '0;
        else if (move_any) pend_q <= '{vld: 1'b1, dir: in_dir};
    end

    // Old-cell attributes sample the pre-move cursor and the pre-toggle grid bit.
    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            cursor_col <= 4'd0;
            cursor_row <= 4'd0;
            X          <= cell_x(4'd0);
            Y          <= cell_y(4'd0);
            OLD_X      <= cell_x(4'd0);
            OLD_Y      <= cell_y(4'd0);
            state      <= 1'b0;
        end else if (launch) begin
            cursor_col <= nxt_col;
            cursor_row <= nxt_row;
            X          <= cell_x(nxt_col);
            Y          <= cell_y(nxt_row);
            OLD_X      <= cell_x(cursor_col);
            OLD_Y      <= cell_y(cursor_row);
            state      <= cur_bit;
        end
    end

    assign busy = (fsm_q != IDLE) | pend_q.vld;

    step_grid_store u_store (
        .CLOCK_50  (CLOCK_50),
        .nReset    (nReset),
        .tgl_en    (btn_toggle),
        .tgl_row   (cursor_row),
        .tgl_col   (cursor_col),
        .rd_row    (cursor_row),
        .rd_col    (cursor_col),
        .rd_bit    (cur_bit),
        .play_col  (play_col),
        .play_bits (play_bits)
    );

endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// Directed bench for grid_cursor_ctrl with a hand-stepped display busy model.
module tb_grid_cursor_ctrl;

    logic        CLOCK_50 = 1'b0;
    logic        nReset;
    logic        btn_up, btn_down, btn_left, btn_right, btn_toggle;
    logic        drawing;
    logic        draw_enable;
    logic [9:0]  X, OLD_X;
    logic [8:0]  Y, OLD_Y;
    logic        state;
    logic [3:0]  cursor_col, cursor_row;
    logic        busy;
    logic [3:0]  play_col;
    logic [11:0] play_bits;

    int tests = 0;
    int fails = 0;
    int de_cnt = 0;

    grid_cursor_ctrl dut (
        .CLOCK_50    (CLOCK_50),
        .nReset      (nReset),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_toggle  (btn_toggle),
        .drawing     (drawing),
        .draw_enable (draw_enable),
        .X           (X),
        .Y           (Y),
        .OLD_X       (OLD_X),
        .OLD_Y       (OLD_Y),
        .state       (state),
        .cursor_col  (cursor_col),
        .cursor_row  (cursor_row),
        .busy        (busy),
        .play_col    (play_col),
        .play_bits   (play_bits)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) if (draw_enable === 1'b1) de_cnt <= de_cnt + 1;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // which: 0 up, 1 down, 2 left, 3 right, 4 toggle
    task automatic pulse(input int which);
        btn_up     = (which == 0);
        btn_down   = (which == 1);
        btn_left   = (which == 2);
        btn_right  = (which == 3);
        btn_toggle = (which == 4);
        tick();
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_toggle = 0;
    endtask

    // Display model: cursor paint, one-cycle dip, box paint, then wait for the controller to go idle.
    task automatic paint();
        int n;
        drawing = 1; repeat (4) tick();
        drawing = 0; tick();
        drawing = 1; repeat (4) tick();
        drawing = 0;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin tick(); n++; end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL paint_done: busy=%b want 0", busy); end
    endtask

    task automatic init_paint(input string tag);
        int n;
        drawing = 1; repeat (10) tick();
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL %s_busy_during_init: got %b want 1", tag, busy); end
        drawing = 0;
        n = 0;
        while (busy !== 1'b0 && n < 5) begin tick(); n++; end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL %s_busy_fall: got %b want 0", tag, busy); end
    endtask

    task automatic test_reset();
        nReset = 0; drawing = 0; play_col = 0;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_toggle = 0;
        #15;
        tests++;
        if (busy !== 1'b1 || draw_enable !== 1'b0) begin
            fails++; $display("FAIL reset_ctrl: busy=%b de=%b want 1/0", busy, draw_enable);
        end
        tests++;
        if (X !== 10'd214 || Y !== 9'd32 || OLD_X !== 10'd214 || OLD_Y !== 9'd32) begin
            fails++; $display("FAIL reset_xy: X=%0d Y=%0d OX=%0d OY=%0d want 214 32 214 32", X, Y, OLD_X, OLD_Y);
        end
        tests++;
        if (state !== 1'b0 || cursor_col !== 4'd0 || cursor_row !== 4'd0 || play_bits !== 12'h000) begin
            fails++; $display("FAIL reset_misc: st=%b col=%0d row=%0d pb=%h want 0 0 0 000", state, cursor_col, cursor_row, play_bits);
        end
        nReset = 1;
        tick();
        init_paint("init");
        tests++;
        if (X !== 10'd214 || Y !== 9'd32 || OLD_X !== 10'd214 || OLD_Y !== 9'd32 || state !== 1'b0) begin
            fails++; $display("FAIL init_outputs: X=%0d Y=%0d OX=%0d OY=%0d st=%b", X, Y, OLD_X, OLD_Y, state);
        end
    endtask

    task automatic test_right_move();
        logic bad_busy, bad_hold;
        int n;
        bad_busy = 0; bad_hold = 0;
        pulse(3);
        tests++;
        if (draw_enable !== 1'b1) begin fails++; $display("FAIL right_de: got %b want 1", draw_enable); end
        tests++;
        if (X !== 10'd247 || OLD_X !== 10'd214 || state !== 1'b0 || cursor_col !== 4'd1) begin
            fails++; $display("FAIL right_latch: X=%0d OX=%0d st=%b col=%0d want 247 214 0 1", X, OLD_X, state, cursor_col);
        end
        drawing = 1;
        tick();
        tests++;
        if (draw_enable !== 1'b0) begin fails++; $display("FAIL right_de_one_cycle: got %b want 0", draw_enable); end
        repeat (3) begin tick(); if (busy !== 1'b1) bad_busy = 1; end
        drawing = 0;
        tick();
        if (busy !== 1'b1) bad_busy = 1;
        if (X !== 10'd247 || OLD_X !== 10'd214 || draw_enable !== 1'b0) bad_hold = 1;
        drawing = 1;
        repeat (4) begin tick(); if (busy !== 1'b1) bad_busy = 1; end
        drawing = 0;
        tests++;
        if (bad_busy) begin fails++; $display("FAIL right_busy_hold: busy dropped early want 1"); end
        tests++;
        if (bad_hold) begin fails++; $display("FAIL right_out_hold: X=%0d OX=%0d changed during request", X, OLD_X); end
        n = 0;
        while (busy !== 1'b0 && n < 5) begin tick(); n++; end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL right_done: busy=%b want 0", busy); end
    endtask

    task automatic test_wrap();
        pulse(2); paint();
        pulse(2);
        tests++;
        if (cursor_col !== 4'd11 || X !== 10'd577 || OLD_X !== 10'd214) begin
            fails++; $display("FAIL wrap_left: col=%0d X=%0d OX=%0d want 11 577 214", cursor_col, X, OLD_X);
        end
        paint();
        pulse(0);
        tests++;
        if (cursor_row !== 4'd11 || Y !== 9'd395 || OLD_Y !== 9'd32 || X !== 10'd577) begin
            fails++; $display("FAIL wrap_up: row=%0d Y=%0d OY=%0d X=%0d want 11 395 32 577", cursor_row, Y, OLD_Y, X);
        end
        paint();
        pulse(3);
        tests++;
        if (cursor_col !== 4'd0 || X !== 10'd214 || OLD_X !== 10'd577) begin
            fails++; $display("FAIL wrap_right: col=%0d X=%0d OX=%0d want 0 214 577", cursor_col, X, OLD_X);
        end
        paint();
        pulse(1);
        tests++;
        if (cursor_row !== 4'd0 || Y !== 9'd32 || OLD_Y !== 9'd395) begin
            fails++; $display("FAIL wrap_down: row=%0d Y=%0d OY=%0d want 0 32 395", cursor_row, Y, OLD_Y);
        end
        paint();
    endtask

    task automatic test_toggle_move();
        play_col = 0;
        tick();
        tests++;
        if (play_bits !== 12'h000) begin fails++; $display("FAIL pre_toggle_col0: got %h want 000", play_bits); end
        pulse(4);
        tests++;
        if (play_bits !== 12'h001 || draw_enable !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL toggle_col0: pb=%h de=%b busy=%b want 001 0 0", play_bits, draw_enable, busy);
        end
        pulse(3);
        tests++;
        if (state !== 1'b1 || OLD_X !== 10'd214 || X !== 10'd247) begin
            fails++; $display("FAIL toggle_then_right: st=%b OX=%0d X=%0d want 1 214 247", state, OLD_X, X);
        end
        paint();
        // toggle and move together: toggle hits (1,0), old-cell bit is the pre-toggle value
        btn_toggle = 1; btn_right = 1;
        tick();
        btn_toggle = 0; btn_right = 0;
        tests++;
        if (state !== 1'b0 || OLD_X !== 10'd247 || X !== 10'd280 || cursor_col !== 4'd2) begin
            fails++; $display("FAIL toggle_with_move: st=%b OX=%0d X=%0d col=%0d want 0 247 280 2", state, OLD_X, X, cursor_col);
        end
        paint();
        play_col = 1;
        tick();
        tests++;
        if (play_bits !== 12'h001) begin fails++; $display("FAIL play_col1: got %h want 001", play_bits); end
        play_col = 12;
        tick();
        tests++;
        if (play_bits !== 12'h000) begin fails++; $display("FAIL play_col12: got %h want 000", play_bits); end
        play_col = 0;
    endtask

    task automatic test_buffer_priority();
        int base, n;
        base = de_cnt;
        btn_down = 1; btn_left = 1;
        tick();
        btn_down = 0; btn_left = 0;
        tests++;
        if (cursor_row !== 4'd1 || cursor_col !== 4'd2 || Y !== 9'd65 || X !== 10'd280) begin
            fails++; $display("FAIL prio_down_left: row=%0d col=%0d Y=%0d X=%0d want 1 2 65 280", cursor_row, cursor_col, Y, X);
        end
        drawing = 1;
        tick();
        pulse(0);
        pulse(3);
        tick();
        drawing = 0; tick();
        drawing = 1; repeat (4) tick();
        drawing = 0;
        n = 0;
        while (draw_enable !== 1'b1 && n < 10) begin tick(); n++; end
        tests++;
        if (draw_enable !== 1'b1) begin fails++; $display("FAIL buffered_launch: de=%b want 1", draw_enable); end
        tests++;
        if (cursor_row !== 4'd1 || cursor_col !== 4'd3 || X !== 10'd313 || OLD_X !== 10'd280 || Y !== 9'd65) begin
            fails++; $display("FAIL buffered_last: row=%0d col=%0d X=%0d OX=%0d Y=%0d want 1 3 313 280 65", cursor_row, cursor_col, X, OLD_X, Y);
        end
        paint();
        repeat (3) tick();
        tests++;
        if (de_cnt - base !== 2) begin fails++; $display("FAIL draw_pulse_count: got %0d want 2", de_cnt - base); end
    endtask

    task automatic test_async_reset();
        int base;
        pulse(2);
        drawing = 1; tick(); tick();
        drawing = 0; tick();
        btn_right = 1; tick(); btn_right = 0;
        #3 nReset = 0;
        #1;
        tests++;
        if (draw_enable !== 1'b0 || busy !== 1'b1 || state !== 1'b0 || cursor_col !== 4'd0 || cursor_row !== 4'd0) begin
            fails++; $display("FAIL areset_ctrl: de=%b busy=%b st=%b col=%0d row=%0d", draw_enable, busy, state, cursor_col, cursor_row);
        end
        tests++;
        if (X !== 10'd214 || Y !== 9'd32 || OLD_X !== 10'd214 || OLD_Y !== 9'd32 || play_bits !== 12'h000) begin
            fails++; $display("FAIL areset_xy: X=%0d Y=%0d OX=%0d OY=%0d pb=%h", X, Y, OLD_X, OLD_Y, play_bits);
        end
        #4 nReset = 1;
        tick();
        base = de_cnt;
        init_paint("reinit");
        repeat (3) tick();
        tests++;
        if (de_cnt !== base || busy !== 1'b0 || cursor_col !== 4'd0) begin
            fails++; $display("FAIL areset_pending_dropped: draws=%0d busy=%b col=%0d want 0 0 0", de_cnt - base, busy, cursor_col);
        end
        play_col = 0; tick();
        tests++;
        if (play_bits !== 12'h000) begin fails++; $display("FAIL areset_grid_col0: got %h want 000", play_bits); end
        play_col = 1; tick();
        tests++;
        if (play_bits !== 12'h000) begin fails++; $display("FAIL areset_grid_col1: got %h want 000", play_bits); end
    endtask

    initial begin
        test_reset();
        test_right_move();
        test_wrap();
        test_toggle_move();
        test_buffer_priority();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
